// File: rtl/cnt_mon_pkg.sv
// Shared types and helpers for the count-stream monitor.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cnt_mon_pkg;

    // Checker state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } mon_state_t;

    // Sample layout: the error tag sits just above the count value bits
    function automatic int err_bit_pos(input int cnt_w);
        return cnt_w;
    endfunction

    // Ceiling log2, used for FIFO index and level widths
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// Latency: a push at edge N is visible at the head after edge N; no same-cycle bypass.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo
    import cnt_mon_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    // Head reads as zero when nothing is buffered, so stale storage never leaks out
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Pointer update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_stream_monitor.sv
// Checks an upstream counter steps by +1, tags samples with an error bit, counts wraps, buffers samples.
// Latency: sample taken at edge N is at m_data with m_valid=1 after edge N.
// Backpressure: m_valid/m_ready; when the FIFO is full a new sample is dropped and ovf_o latches.
module cnt_stream_monitor
    import cnt_mon_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int DEPTH  = 8,
    parameter int WRAP_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [CNT_W-1:0]         cnt_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNT_W:0]           m_data,
    output logic [WRAP_W-1:0]        wrap_cnt_o,
    output logic                     step_err_o,
    output logic                     ovf_o,
    output logic [clog2(DEPTH):0]    level_o
);

    localparam int ERR_BIT = err_bit_pos(CNT_W);

    mon_state_t       state;
    logic [CNT_W-1:0] prev;
    logic [CNT_W-1:0] prev_inc;
    logic             push_vld;
    logic [CNT_W:0]   push_dat;
    logic             step_bad;
    logic             wrap_hit;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_rdy;
    logic             drop;

    assign prev_inc = prev + CNT_W'(1);
    assign m_valid  = !fifo_empty;
    assign pop_rdy  = m_valid && m_ready;
    assign drop     = push_vld && fifo_full && !pop_rdy;

    // Decide whether this cycle's count is pushed, and classify it
    always_comb begin
        push_vld = 1'b0;
        push_dat = '0;
        step_bad = 1'b0;
        wrap_hit = 1'b0;
        case (state)
            ARM: begin
                push_vld = 1'b1;
                push_dat = {1'b0, cnt_i};
            end
            RUN: begin
                // An unchanged count means the upstream counter is stalled: nothing to record
                if (en_i && (cnt_i != prev)) begin
                    push_vld          = 1'b1;
                    step_bad          = (cnt_i != prev_inc);
                    push_dat          = {1'b0, cnt_i};
                    push_dat[ERR_BIT] = step_bad;
                    // Only a genuine all-ones -> zero step counts as a wrap
                    wrap_hit          = !step_bad && (prev == '1) && (cnt_i == '0);
                end
            end
            default: ;
        endcase
    end

    // Checker FSM, previous-value tracking, wrap counter and sticky flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            prev       <= '0;
            wrap_cnt_o <= '0;
            step_err_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en_i) state <= ARM;
                ARM: begin
                    prev  <= cnt_i;
                    state <= en_i ? RUN : IDLE;
                end
                RUN: begin
                    if (!en_i)         state <= IDLE;
                    else if (push_vld) prev  <= cnt_i;
                end
                default: state <= IDLE;
            endcase
            // Clear takes priority over any event in the same cycle
            if (clr_i) begin
                wrap_cnt_o <= '0;
                step_err_o <= 1'b0;
                ovf_o      <= 1'b0;
            end else begin
                if (wrap_hit && (wrap_cnt_o != {WRAP_W{1'b1}})) wrap_cnt_o <= wrap_cnt_o + 1'b1;
                if (step_bad) step_err_o <= 1'b1;
                if (drop)     ovf_o      <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .W     (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .head_dat (m_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

endmodule
